// File: rtl/tilt_position_tracker_if.sv
// -----------------------------------------------------------------------------
// tilt_position_tracker_if
// Purpose : bundles the accelerometer sample stream and the position outputs
//           of tilt_position_tracker into one port.
// Signals : in_valid    - in_data valid this cycle (no backpressure)
//           in_data     - signed accelerometer sample, IN_W bits
//           pos_onehot  - one-hot board position, bit 0 = most negative tilt
//           pos_idx     - binary index of pos_onehot
//           pos_valid   - high once the first window has been mapped
//           pos_changed - one-cycle pulse when pos_idx changes
// Modports: master - sample source / position consumer (testbench, game logic)
//           slave  - the tracker itself
// -----------------------------------------------------------------------------
interface tilt_position_tracker_if #(
  parameter int IN_W  = 16,
  parameter int N_POS = 10,
  parameter int IDX_W = $clog2(N_POS)
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic [N_POS-1:0] pos_onehot;
  logic [IDX_W-1:0] pos_idx;
  logic             pos_valid;
  logic             pos_changed;

  modport master (
    output in_valid, in_data,
    input  pos_onehot, pos_idx, pos_valid, pos_changed
  );

  modport slave (
    input  in_valid, in_data,
    output pos_onehot, pos_idx, pos_valid, pos_changed
  );
endinterface

// File: rtl/tilt_position_tracker.sv
// -----------------------------------------------------------------------------
// tilt_position_tracker
// Purpose : box-averages windows of 2^AVG_LOG2 signed accelerometer samples
//           and quantises each average into one of N_POS board positions,
//           with optional hysteresis against the current position.
// Ports   : clk   - system clock
//           reset - synchronous, active-high; discards partial windows and
//                   any in-flight result
//           bus   - tilt_position_tracker_if.slave (sample in, position out)
// Config  : define TILT_TRACK_HYST_EN to build the hysteresis comparison
//           (two extra mappers on avg-HYST / avg+HYST). Without it HYST is
//           ignored and every window result is taken directly.
// Pipeline: ACCUM (accumulator) -> MAP (avg and candidate registered) ->
//           UPD (outputs registered). Outputs change on the 2nd rising edge
//           after the edge that accepts a window's last sample. MAP/UPD
//           overlap with accumulation of the next window, so windows never
//           stall.
// -----------------------------------------------------------------------------
module tilt_position_tracker #(
  parameter int IN_W     = 16,
  parameter int N_POS    = 10,
  parameter int STEP     = 20,
  parameter int HYST     = 4,
  parameter int AVG_LOG2 = 2,
  parameter int IDX_W    = $clog2(N_POS)
) (
  input  logic                    clk,
  input  logic                    reset,
  tilt_position_tracker_if.slave  bus
);

  localparam int ACC_W = IN_W + AVG_LOG2;
  // Two guard bits so v +/- HYST and -(-2^(IN_W-1)) cannot overflow.
  localparam int EXT_W = IN_W + 2;
  // The counter keeps one bit even without averaging; it then stays at 0,
  // which is also the last-sample value, so every sample closes a window.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int HALF  = N_POS / 2;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [EXT_W-1:0] STEP_E      = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] K_LIM       = EXT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_RST     = IDX_W'(HALF);
  localparam logic [N_POS-1:0] ONEHOT_LSB  = {{(N_POS-1){1'b0}}, 1'b1};
  localparam logic [N_POS-1:0] ONEHOT_RST  = ONEHOT_LSB << HALF;

  // Maps a value to a position index. Positive values use (v-1)/STEP so that
  // 1..STEP land in the first bin above centre and 0 joins it; negative values
  // use |v|/STEP so that -1..-(STEP-1) land just below centre.
  function automatic logic [IDX_W-1:0] map_pos(input logic signed [EXT_W-1:0] v);
    logic [EXT_W-1:0] mag;
    logic [EXT_W-1:0] k;
    logic [IDX_W-1:0] idx;
    if (v[EXT_W-1] == 1'b0) begin
      if (v == {EXT_W{1'b0}}) begin
        mag = {EXT_W{1'b0}};
      end else begin
        mag = $unsigned(v) - EXT_W'(1);
      end
      k = mag / STEP_E;
      if (k >= K_LIM) begin
        idx = IDX_W'(N_POS - 1);
      end else begin
        idx = IDX_W'(HALF) + k[IDX_W-1:0];
      end
    end else begin
      mag = $unsigned(-v);
      k   = mag / STEP_E;
      if (k >= K_LIM) begin
        idx = IDX_W'(0);
      end else begin
        idx = IDX_W'(HALF - 1) - k[IDX_W-1:0];
      end
    end
    return idx;
  endfunction

  // ACCUM stage
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    sum_vld_q, sum_vld_d;
  logic signed [ACC_W-1:0] sample_ext_s;

  // MAP stage
  logic signed [IN_W-1:0]  avg_s;
  logic signed [EXT_W-1:0] avg_ext_s;
  logic        [IDX_W-1:0] cand_q, cand_d;
  logic                    map_vld_q, map_vld_d;
`ifdef TILT_TRACK_HYST_EN
  localparam logic signed [EXT_W-1:0] HYST_E = EXT_W'(HYST);
  logic        [IDX_W-1:0] cand_lo_q, cand_lo_d;  // map(avg - HYST)
  logic        [IDX_W-1:0] cand_hi_q, cand_hi_d;  // map(avg + HYST)
`endif

  // UPD stage
  logic [IDX_W-1:0] next_idx_s;
  logic [IDX_W-1:0] pos_idx_q, pos_idx_d;
  logic [N_POS-1:0] pos_onehot_q, pos_onehot_d;
  logic             pos_valid_q, pos_valid_d;
  logic             pos_changed_q, pos_changed_d;

  // Accumulate samples; on the window's last sample hand the full sum to MAP
  // and restart the accumulator in the same cycle.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    sum_vld_d    = 1'b0;
    sample_ext_s = ACC_W'($signed(bus.in_data));
    if (bus.in_valid) begin
      if (cnt_q == CNT_LAST) begin
        sum_d     = acc_q + sample_ext_s;
        sum_vld_d = 1'b1;
        acc_d     = {ACC_W{1'b0}};
        cnt_d     = {CNT_W{1'b0}};
      end else begin
        acc_d = acc_q + sample_ext_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Average (arithmetic shift floors toward -inf) and map to candidate index.
  always_comb begin
    avg_s     = IN_W'(sum_q >>> AVG_LOG2);
    avg_ext_s = EXT_W'(avg_s);
    map_vld_d = sum_vld_q;
    if (sum_vld_q) begin
      cand_d = map_pos(avg_ext_s);
    end else begin
      cand_d = cand_q;
    end
`ifdef TILT_TRACK_HYST_EN
    if (sum_vld_q) begin
      cand_lo_d = map_pos(avg_ext_s - HYST_E);
      cand_hi_d = map_pos(avg_ext_s + HYST_E);
    end else begin
      cand_lo_d = cand_lo_q;
      cand_hi_d = cand_hi_q;
    end
`endif
  end

  // Decide the new position. The first result is always taken; with
  // hysteresis a move needs the margin-shifted average to agree.
  always_comb begin
    next_idx_s = pos_idx_q;
    if (map_vld_q) begin
      if (!pos_valid_q) begin
        next_idx_s = cand_q;
      end else begin
`ifdef TILT_TRACK_HYST_EN
        if ((cand_q > pos_idx_q) && (cand_lo_q > pos_idx_q)) begin
          next_idx_s = cand_q;
        end else if ((cand_q < pos_idx_q) && (cand_hi_q < pos_idx_q)) begin
          next_idx_s = cand_q;
        end else begin
          next_idx_s = pos_idx_q;
        end
`else
        next_idx_s = cand_q;
`endif
      end
    end else begin
      next_idx_s = pos_idx_q;
    end
    pos_idx_d     = next_idx_s;
    pos_onehot_d  = ONEHOT_LSB << next_idx_s;
    pos_valid_d   = pos_valid_q | map_vld_q;
    pos_changed_d = map_vld_q & (next_idx_s != pos_idx_q);
  end

  // Pipeline and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= {ACC_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      sum_q         <= {ACC_W{1'b0}};
      sum_vld_q     <= 1'b0;
      cand_q        <= IDX_RST;
      map_vld_q     <= 1'b0;
`ifdef TILT_TRACK_HYST_EN
      cand_lo_q     <= IDX_RST;
      cand_hi_q     <= IDX_RST;
`endif
      pos_idx_q     <= IDX_RST;
      pos_onehot_q  <= ONEHOT_RST;
      pos_valid_q   <= 1'b0;
      pos_changed_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      sum_vld_q     <= sum_vld_d;
      cand_q        <= cand_d;
      map_vld_q     <= map_vld_d;
`ifdef TILT_TRACK_HYST_EN
      cand_lo_q     <= cand_lo_d;
      cand_hi_q     <= cand_hi_d;
`endif
      pos_idx_q     <= pos_idx_d;
      pos_onehot_q  <= pos_onehot_d;
      pos_valid_q   <= pos_valid_d;
      pos_changed_q <= pos_changed_d;
    end
  end

  assign bus.pos_idx     = pos_idx_q;
  assign bus.pos_onehot  = pos_onehot_q;
  assign bus.pos_valid   = pos_valid_q;
  assign bus.pos_changed = pos_changed_q;

endmodule

// File: doc/tilt_position_tracker.md
# tilt_position_tracker

Parametrised, clocked successor to the combinational tilt-to-LED remapper. Accepts a stream of signed accelerometer samples, box-averages fixed-size windows, and quantises the average into one of N_POS board positions with optional hysteresis. Outputs a registered one-hot LED vector plus index, valid and change strobes. Sits between the accelerometer sample interface and the game/LED logic.

## Interface
- IN_W, 16, sample width (two's complement)
- N_POS, 10, number of positions/LEDs; even, ≥ 2
- STEP, 20, bin width in sample LSBs
- HYST, 4, hysteresis margin in LSBs (used only with TILT_TRACK_HYST_EN)
- AVG_LOG2, 2, window = 2^AVG_LOG2 samples; 0 = no averaging
- IDX_W, $clog2(N_POS), index width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_data valid this cycle; no backpressure
- in_data  in  IN_W  signed sample
- pos_onehot  out  N_POS  registered one-hot position; bit 0 = most negative tilt
- pos_idx  out  IDX_W  binary index of pos_onehot
- pos_valid  out  1  high once the first window has been mapped
- pos_changed  out  1  one-cycle pulse when pos_idx changes

## Operation
- Accumulator: signed, IN_W+AVG_LOG2 bits; sample counter AVG_LOG2 bits. Each in_valid adds in_data; gaps in in_valid are allowed.
- When the window's last sample is accepted: sum is latched into a pipeline register, and the accumulator/counter clear to 0 in the same cycle. A new window starts on the next in_valid. Windows never stall.
- avg = sum >>> AVG_LOG2 (arithmetic, floor toward −∞), IN_W bits.
- map(v), evaluated in IN_W+2 bits so that v ± HYST and negation of −2^(IN_W−1) cannot overflow:
  - v ≥ 0: k = 0 if v = 0, else (v−1)/STEP; idx = min(N_POS/2 + k, N_POS−1).
  - v < 0: a = −v; idx = max(N_POS/2 − 1 − a/STEP, 0).
  - With defaults: −80→0, −79..−60→1, −20→3, −19..−1→4, 0..20→5, 21..40→6, 81+→9.
- Update, with cand = map(avg) and cur = pos_idx:
  - pos_valid = 0: take cand and set pos_valid = 1.
  - Hysteresis on, cand > cur: move to cand only if map(avg−HYST) > cur, else hold.
  - Hysteresis on, cand < cur: move to cand only if map(avg+HYST) < cur, else hold.
  - Hysteresis off: always take cand.
- pos_changed pulses only when pos_idx actually changes. The first window after reset pulses only if cand ≠ N_POS/2.
- pos_onehot is always exactly 1 << pos_idx and never all-zero or X.
- Pipeline states: ACCUM (collecting) → MAP (avg/cand registered) → UPD (outputs written). MAP/UPD run in parallel with accumulation of the next window.

## Timing
- Reset values: pos_idx = N_POS/2, pos_onehot = 1 << (N_POS/2), pos_valid = 0, pos_changed = 0; accumulator, counter and pipeline cleared.
- Latency: outputs change on the 2nd rising edge after the edge that accepted the window's last sample.
- With AVG_LOG2 = 0, back-to-back samples give one update per cycle.
- Reset asserted mid-window discards partial sums and any in-flight MAP/UPD result. Samples presented while reset is high are ignored.
- pos_changed is high for exactly one cycle per change.

## Configuration
- TILT_TRACK_HYST_EN defined: hysteresis comparison per Operation; the two extra mappers are instantiated.
- TILT_TRACK_HYST_EN undefined: HYST is ignored, cand is taken directly, and the extra mappers are not built. Latency is unchanged.

## Test plan
- Reset, then no input → pos_onehot = 10'b00_0010_0000, pos_idx = 5, pos_valid = 0, pos_changed = 0.
- Four samples of +85 with idle gaps → two edges after the 4th sample: pos_idx = 9, pos_onehot = 10'b10_0000_0000, pos_valid = 1, one-cycle pos_changed.
- Build without macro, AVG_LOG2 = 0; sweep −80, −79, −20, −1, 0, 20, 21, 81, −32768, 32767 → indices 0, 1, 3, 4, 5, 5, 6, 9, 0, 9.
- With macro, window average 30 → idx 6; next average 42 → hold at 6, no pulse (map(38) = 6); next average 45 → idx 7 with pulse (map(41) = 7).
- Samples −1, −1, −1, 0 → sum −3, avg −1 → idx 4 (floor rounding).
- Two samples of −90, then reset, then four of +30 → pos_idx = 6; post-reset result unaffected by pre-reset samples.
